// File: rtl/example_logic.sv
// Three-input glue function y = (~b & ~c) | (a & ~b) with a registered copy,
// a minterm coverage mask and a saturating rising-edge counter on y_q.
module example_logic #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic             y_q,
  output logic [7:0]       seen,
  output logic [CNT_W-1:0] rise_cnt
);

  always_comb begin
    y = (~b & ~c) | (a & ~b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q      <= 1'b0;
      seen     <= '0;
      rise_cnt <= '0;
    end else begin
      y_q           <= y;
      seen[{a,b,c}] <= 1'b1;
      // edge is old y_q low and new y high; hold at all-ones instead of wrapping
      if (!y_q && y && (rise_cnt != '1))
        rise_cnt <= rise_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_example_logic.sv
// Directed self-checking bench for example_logic (default width and CNT_W=2).
module tb_example_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, b, c;
  logic       y, y_q;
  logic [7:0] seen;
  logic [7:0] rise_cnt;
  logic       y2, y_q2;
  logic [7:0] seen2;
  logic [1:0] rise_cnt2;

  int checks = 0;
  int errors = 0;

  example_logic #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
    .y(y), .y_q(y_q), .seen(seen), .rise_cnt(rise_cnt)
  );

  example_logic #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
    .y(y2), .y_q(y_q2), .seen(seen2), .rise_cnt(rise_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive inputs, take one edge, sample 1 ns later
  task automatic step(input logic [2:0] abc, input logic rst);
    {a, b, c} = abc;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  // truth table of y indexed by {a,b,c}
  logic       exp_y [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] exp_sat [10] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    {a, b, c} = 3'b000;
    reset     = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    chk("rst_y_q", 32'(y_q), 32'd0);
    chk("rst_seen", 32'(seen), 32'h00);
    chk("rst_rise", 32'(rise_cnt), 32'd0);

    // exhaustive combinational (reset held so state does not matter)
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #10;
      chk($sformatf("comb_y_%0d", i), 32'(y), 32'(exp_y[i]));
    end

    // registered path and full coverage
    step(3'b000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b0);
      chk($sformatf("reg_y_q_%0d", i), 32'(y_q), 32'(exp_y[i]));
    end
    chk("full_seen", 32'(seen), 32'hFF);
    chk("full_rise", 32'(rise_cnt), 32'd2);

    // partial coverage
    step(3'b000, 1'b1);
    step(3'b000, 1'b0);
    step(3'b101, 1'b0);
    chk("part_seen", 32'(seen), 32'h21);
    chk("part_rise", 32'(rise_cnt), 32'd1);
    chk("part_y_q", 32'(y_q), 32'd1);

    // reset mid-run
    step(3'b000, 1'b1);
    step(3'b000, 1'b0);
    step(3'b001, 1'b0);
    chk("mid_pre_rise", 32'(rise_cnt), 32'd1);
    chk("mid_pre_seen", 32'(seen), 32'h03);
    {a, b, c} = 3'b100;
    reset     = 1'b1;
    #1;
    chk("mid_y_in_reset", 32'(y), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_y_q", 32'(y_q), 32'd0);
    chk("mid_seen", 32'(seen), 32'h00);
    chk("mid_rise", 32'(rise_cnt), 32'd0);
    chk("mid_y_after", 32'(y), 32'd1);

    // steady high after reset
    for (int i = 0; i < 5; i++) begin
      step(3'b100, 1'b0);
      chk($sformatf("hold_y_q_%0d", i), 32'(y_q), 32'd1);
      chk($sformatf("hold_rise_%0d", i), 32'(rise_cnt), 32'd1);
      chk($sformatf("hold_seen_%0d", i), 32'(seen), 32'h10);
    end

    // saturation on the 2-bit counter instance
    step(3'b000, 1'b1);
    chk("sat_rst", 32'(rise_cnt2), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 3'b000 : 3'b001, 1'b0);
      chk($sformatf("sat_rise_%0d", i), 32'(rise_cnt2), 32'(exp_sat[i]));
    end
    chk("sat_wide_rise", 32'(rise_cnt), 32'd5);
    chk("sat_seen", 32'(seen2), 32'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/example_logic.md
# example_logic

Three-input combinational logic function with a registered copy of its output and simple observability counters. Inputs `a`, `b`, `c` drive the function `y = (~b & ~c) | (a & ~b)`. The combinational result is also captured each clock. The block records which of the eight input combinations have been applied and counts rising edges of the registered output. It is a leaf block used as a small glue-logic function and as a bring-up and coverage aid.

## Interface
Parameters:
- `CNT_W`, default 8: width of the rising-edge counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `a`, input, 1: function input (MSB of the minterm index).
- `b`, input, 1: function input (middle bit of the minterm index).
- `c`, input, 1: function input (LSB of the minterm index).
- `y`, output, 1: combinational function output.
- `y_q`, output, 1: `y` registered on `clk`.
- `seen`, output, 8: minterm coverage mask; bit `{a,b,c}` is set once that combination has been sampled.
- `rise_cnt`, output, CNT_W: saturating count of 0→1 transitions of `y_q`.

## Operation
- Truth table of `y`, indexed `abc`:
  - 000 → 1
  - 001 → 0
  - 010 → 0
  - 011 → 0
  - 100 → 1
  - 101 → 1
  - 110 → 0
  - 111 → 0
- `y` is purely combinational; it has no dependence on `clk` or `reset`.
- On each rising edge of `clk` with `reset`=0:
  - `y_q` ← `y`.
  - `seen[{a,b,c}]` ← 1. All other bits of `seen` hold.
  - If the old `y_q`=0 and the new `y`=1, `rise_cnt` increments by 1.
  - `rise_cnt` saturates at 2^CNT_W−1; it never wraps.
- On a rising edge with `reset`=1, regardless of the inputs:
  - `y_q` = 0.
  - `seen` = 8'h00.
  - `rise_cnt` = 0.
- Reset takes priority over every update in the same cycle.
- The first sample after reset that produces `y`=1 counts as a rising edge, because `y_q` resets to 0.
- Reset asserted mid-sequence clears all state on that edge. Counting resumes from 0 on the first edge with `reset`=0.
- An X or Z on any input is not supported; the behaviour of all outputs is then unspecified.

## Timing
- `y`: zero-cycle combinational path from `a`, `b`, `c`.
- `y_q`, `seen`, `rise_cnt`: one-cycle latency. Each reflects the inputs sampled at the most recent rising edge of `clk`.
- No handshake. Inputs are sampled every cycle and must meet setup and hold at `clk`.
- `seen` and `rise_cnt` are monotonic between resets.
- Reset values: `y_q`=0, `seen`=0, `rise_cnt`=0. `y` follows its inputs even while `reset` is high.

## Test plan
- Exhaustive combinational check:
  - Step `abc` through 000, 001, 010, 011, 100, 101, 110, 111, allowing 10 ns of settle time per step.
  - Required `y` = 1, 0, 0, 0, 1, 1, 0, 0.
- Registered path and coverage:
  - Assert reset for 1 cycle, then apply the same 8-vector sequence, one vector per clock.
  - Required `y_q` lags `y` by exactly 1 cycle.
  - Required final `seen` = 8'hFF.
  - Required final `rise_cnt` = 2: one edge at `abc`=000, one at `abc`=100.
- Partial coverage:
  - After reset, apply only 000 and 101.
  - Required `seen` = 8'h21 and `rise_cnt` = 1.
- Reset mid-run:
  - Apply 000, then 001, then 100 with `reset`=1 on the 100 edge.
  - Required on the next cycle: `y_q`=0, `seen`=0, `rise_cnt`=0.
  - Required: `y`=1 combinationally throughout the reset cycle.
- Saturation:
  - With CNT_W=2, alternate `abc` between 000 and 001 for 10 cycles.
  - Required `rise_cnt` stops at 3 and holds.
- Steady high:
  - Hold `abc`=100 for 5 cycles after reset.
  - Required `y_q`=1 from cycle 1 onward, `rise_cnt`=1, `seen`=8'h10.
